// File: rtl/uart_cmd_master.sv
// Host-side initiator for the 2-byte UART register-access protocol, with its own
// 8N1 uart core. Each request is a command byte {~write, addr} plus a data byte
// for writes; reads wait for one response byte or time out.

module uart #(
  parameter int freq_hz = 64*115200,
  parameter int baud    = 115_200
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       rxd,
  output logic       txd,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  output logic       rx_error,
  input  logic       rx_ack
);
  localparam int DIV = freq_hz / baud;
  localparam int CW  = $clog2(DIV + 1);

  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [3:0]    tx_bits, rx_bits;
  logic [8:0]    tx_sh;
  logic [7:0]    rx_sh;
  logic [1:0]    rx_sync;
  logic          rx_busy;

  assign tx_busy = (tx_bits != 4'd0);

  // tx_bits counts remaining bit periods: start, 8 data, stop
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      txd     <= 1'b1;
      tx_sh   <= '1;
      tx_cnt  <= '0;
      tx_bits <= '0;
    end else if (tx_bits == 4'd0) begin
      if (tx_wr) begin
        txd     <= 1'b0;
        tx_sh   <= {1'b1, tx_data};
        tx_cnt  <= CW'(DIV - 1);
        tx_bits <= 4'd10;
      end
    end else if (tx_cnt != '0) begin
      tx_cnt <= tx_cnt - 1'b1;
    end else begin
      tx_cnt  <= CW'(DIV - 1);
      tx_bits <= tx_bits - 1'b1;
      txd     <= tx_sh[0];
      tx_sh   <= {1'b1, tx_sh[8:1]};
    end
  end

  // Receiver samples mid-bit; a start bit that is high again at mid-bit is a glitch
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rx_sync  <= 2'b11;
      rx_busy  <= 1'b0;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_avail <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rxd};
      if (rx_ack) begin
        rx_avail <= 1'b0;
        rx_error <= 1'b0;
      end
      if (!rx_busy) begin
        if (!rx_sync[1]) begin
          rx_busy <= 1'b1;
          rx_cnt  <= CW'(DIV/2 - 1);
          rx_bits <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt <= CW'(DIV - 1);
        if (rx_bits == 4'd0 && rx_sync[1]) begin
          rx_busy <= 1'b0;
        end else if (rx_bits == 4'd9) begin
          rx_busy  <= 1'b0;
          rx_data  <= rx_sh;
          rx_avail <= 1'b1;
          rx_error <= ~rx_sync[1];
        end else begin
          if (rx_bits != 4'd0) rx_sh <= {rx_sync[1], rx_sh[7:1]};
          rx_bits <= rx_bits + 1'b1;
        end
      end
    end
  end
endmodule

module uart_cmd_master #(
  parameter int UART_CLK_FREQ = 64*115200,
  parameter int UART_BAUD     = 115_200,
  parameter int RSP_TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       uart_txd,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_timeout
);
  localparam int TW = $clog2(RSP_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CMD, CMD_G, DATA, RSP, DONE} state_t;

  state_t        state;
  logic          wr_q, data_sent;
  logic [6:0]    addr_q;
  logic [7:0]    wdata_q;
  logic [TW-1:0] timer;
  logic          tx_wr, tx_busy, rx_avail, rx_error;
  logic [7:0]    tx_data, rx_data;

  uart #(.freq_hz(UART_CLK_FREQ), .baud(UART_BAUD)) u_uart (
    .clk      (clk),
    .n_reset  (~reset),
    .rxd      (uart_rxd),
    .txd      (uart_txd),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_busy  (tx_busy),
    .rx_data  (rx_data),
    .rx_avail (rx_avail),
    .rx_error (rx_error),
    .rx_ack   (rx_avail)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      data_sent   <= 1'b0;
      timer       <= '0;
      tx_wr       <= 1'b0;
      tx_data     <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      tx_wr <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            wr_q      <= req_write;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            state     <= CMD;
          end
        end
        CMD: if (!tx_busy) begin
          tx_wr   <= 1'b1;
          tx_data <= {~wr_q, addr_q};
          state   <= CMD_G;
        end
        // tx_busy only rises the cycle after tx_wr is seen by the core
        CMD_G: begin
          data_sent <= 1'b0;
          if (wr_q) begin
            state <= DATA;
          end else begin
            timer <= TW'(RSP_TIMEOUT);
            state <= RSP;
          end
        end
        DATA: begin
          if (data_sent) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            state       <= DONE;
          end else if (!tx_busy) begin
            tx_wr     <= 1'b1;
            tx_data   <= wdata_q;
            data_sent <= 1'b1;
          end
        end
        RSP: begin
          if (timer != '0) timer <= timer - 1'b1;
          // a good byte beats an expiring timer in the same cycle
          if (rx_avail && !rx_error) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= rx_data;
            rsp_timeout <= 1'b0;
            state       <= DONE;
          end else if (timer == '0) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          rsp_valid   <= 1'b0;
          rsp_rdata   <= '0;
          rsp_timeout <= 1'b0;
          req_ready   <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_master.sv
// Randomized bench for uart_cmd_master: line decoder, byte responder and a
// per-request model of the bytes sent and the completion returned.

module tb_uart_cmd_master;
  localparam int BIT = 64;
  localparam int TO  = 3000;

  logic       clk = 1'b0, reset = 1'b1, uart_rxd = 1'b1, uart_txd;
  logic       req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_wdata = '0, rsp_rdata;
  logic       rsp_valid, rsp_timeout;

  int n_tests = 0, n_fail = 0, cyc = 0;
  int exp_rsp_total = 0, exp_tx_total = 0;
  logic [7:0] tx_q[$];
  int         tx_start[$];
  logic [8:0] rsp_q[$];
  int         rsp_cyc[$];
  logic       rsp_valid_d = 1'b0;

  uart_cmd_master #(.UART_CLK_FREQ(64*115200), .UART_BAUD(115_200), .RSP_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // 8N1 line decoder on uart_txd, sampling at mid-bit
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && uart_txd === 1'b0) begin
        int t0;
        logic [7:0] b;
        t0 = cyc;
        repeat (BIT/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = uart_txd;
        end
        repeat (BIT) @(negedge clk);
        chk("stop_bit", {31'b0, uart_txd}, 32'd1);
        tx_q.push_back(b);
        tx_start.push_back(t0);
      end
    end
  end

  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_q.push_back({rsp_timeout, rsp_rdata});
      rsp_cyc.push_back(cyc);
      chk("ready_low_at_rsp", {31'b0, req_ready}, 32'd0);
    end
    if (rsp_valid_d) chk("ready_after_rsp", {31'b0, req_ready}, 32'd1);
    rsp_valid_d = rsp_valid;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic wait_tx(input int want);
    int n = 0;
    while (tx_q.size() < want && n < 10000) begin @(negedge clk); n++; end
    if (tx_q.size() < want) chk("tx_wait", tx_q.size(), want);
  endtask

  task automatic wait_rsp(input int want);
    int n = 0;
    while (rsp_q.size() < want && n < 10000) begin @(negedge clk); n++; end
    if (rsp_q.size() < want) chk("rsp_wait", rsp_q.size(), want);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 10000) begin @(negedge clk); n++; end
    if (req_ready !== 1'b1) chk("ready_wait", {31'b0, req_ready}, 32'd1);
  endtask

  // one-cycle request, then scramble inputs to prove they are not resampled
  task automatic issue(input logic w, input logic [6:0] a, input logic [7:0] d);
    wait_ready();
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_addr  = 7'($urandom);
    req_wdata = 8'($urandom);
  endtask

  task automatic txn(input logic w, input logic [6:0] a, input logic [7:0] d,
                     input logic answer, input logic [7:0] rd, input string tag);
    int bt, br;
    logic [7:0] exp_b[$];
    logic [8:0] exp_r;
    bt = tx_q.size();
    br = rsp_q.size();
    exp_b.push_back({~w, a});
    if (w) exp_b.push_back(d);
    exp_r = w ? 9'h000 : (answer ? {1'b0, rd} : 9'h100);
    issue(w, a, d);
    if (!w && answer) begin
      wait_tx(bt + 1);
      repeat ($urandom_range(0, 200)) @(negedge clk);
      send_byte(rd);
    end
    wait_rsp(br + 1);
    wait_tx(bt + exp_b.size());
    if (rsp_q.size() > br) chk({tag, "_rsp"}, {23'b0, rsp_q[br]}, {23'b0, exp_r});
    foreach (exp_b[i])
      if (tx_q.size() > bt + i) chk({tag, "_byte"}, {24'b0, tx_q[bt+i]}, {24'b0, exp_b[i]});
    // line start bit is one cycle after the command tx_wr
    if (!w && !answer && rsp_cyc.size() > br && tx_start.size() > bt)
      chk({tag, "_to_latency"}, rsp_cyc[br] - tx_start[bt], TO + 1);
    exp_rsp_total++;
    exp_tx_total += exp_b.size();
  endtask

  initial begin
    int br, bt, n;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", {24'b0, rsp_rdata}, 32'd0);
    chk("rst_timeout", {31'b0, rsp_timeout}, 32'd0);
    chk("rst_txd", {31'b0, uart_txd}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_release", {31'b0, req_ready}, 32'd1);

    txn(1'b1, 7'h15, 8'hA5, 1'b0, 8'h00, "wr15");
    txn(1'b0, 7'h03, 8'h00, 1'b1, 8'h5C, "rd03");
    txn(1'b0, 7'h7F, 8'h00, 1'b0, 8'h00, "rd7f_to");
    br = rsp_q.size();
    send_byte(8'h11);
    repeat (100) @(negedge clk);
    chk("late_byte_dropped", rsp_q.size(), br);
    txn(1'b1, 7'h33, 8'hC3, 1'b0, 8'h00, "wr_after_to");

    // req_valid held high across two requests
    bt = tx_q.size(); br = rsp_q.size();
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h01; req_wdata = 8'h10;
    @(negedge clk);
    req_write = 1'b0; req_addr = 7'h02; req_wdata = 8'hEE;
    n = 0;
    while (req_ready !== 1'b1 && n < 10000) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0; req_addr = 7'h55; req_wdata = 8'h77;
    wait_tx(bt + 3);
    send_byte(8'h55);
    wait_rsp(br + 2);
    if (rsp_q.size() >= br + 2) begin
      chk("b2b_wr_rsp", {23'b0, rsp_q[br]}, 32'h000);
      chk("b2b_rd_rsp", {23'b0, rsp_q[br+1]}, 32'h055);
    end
    if (tx_q.size() >= bt + 3) begin
      chk("b2b_byte0", {24'b0, tx_q[bt]}, 32'h01);
      chk("b2b_byte1", {24'b0, tx_q[bt+1]}, 32'h10);
      chk("b2b_byte2", {24'b0, tx_q[bt+2]}, 32'h82);
    end
    exp_rsp_total += 2; exp_tx_total += 3;

    br = rsp_q.size();
    send_byte(8'h44);
    repeat (50) @(negedge clk);
    chk("stray_dropped", rsp_q.size(), br);
    txn(1'b0, 7'h20, 8'h00, 1'b1, 8'h99, "rd_after_stray");

    // reset during the data byte of a write
    bt = tx_q.size(); br = rsp_q.size();
    issue(1'b1, 7'h2A, 8'h3C);
    wait_tx(bt + 1);
    repeat (3*BIT) @(negedge clk);
    chk("rst_wr_rsp_count", rsp_q.size(), br + 1);
    if (tx_q.size() > bt) chk("rst_wr_cmd", {24'b0, tx_q[bt]}, 32'h2A);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd0);
    chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_rdata", {24'b0, rsp_rdata}, 32'd0);
    chk("mid_rst_txd", {31'b0, uart_txd}, 32'd1);
    reset = 1'b0;
    br = rsp_q.size();
    repeat (12*BIT) @(negedge clk);
    chk("no_rsp_after_rst", rsp_q.size(), br);
    tx_q.delete(); tx_start.delete(); exp_tx_total = 0;
    exp_rsp_total++;
    txn(1'b0, 7'h00, 8'h00, 1'b1, 8'h01, "rd00_after_rst");

    for (int k = 0; k < 12; k++) begin
      logic w, ans;
      w   = 1'($urandom_range(0, 1));
      ans = (!w) && ($urandom_range(0, 3) != 0);
      txn(w, 7'($urandom), 8'($urandom), ans, 8'($urandom), "rand");
    end

    repeat (100) @(negedge clk);
    chk("rsp_total", rsp_q.size(), exp_rsp_total);
    chk("tx_total", tx_q.size(), exp_tx_total);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
